shift_frame_sequencer: RTL
==========================

Name: shift_frame_sequencer

Overview:
- Upstream feeder for the 8-bit bidirectional shift register.
- Accepts parallel bytes tagged with a shift direction over a valid/ready handshake and buffers them in a small FIFO.
- Drives the register's shift_dir and data_in one bit per clock, so that after 8 shifts the register holds the byte exactly.
- Pulses frame_done in the cycle the register content is complete.

Parameters:
- FIFO_DEPTH, 4, number of buffered {dir, byte} entries; power of two, minimum 2.
- IDLE_BIT, 0, serial value driven while no frame is active.

Ports:
- clk  input  1  single clock; all flops rise-edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- in_valid  input  1  upstream has a byte on in_data/in_dir.
- in_ready  output  1  FIFO can accept; transfer occurs when in_valid && in_ready at a rising edge.
- in_data  input  8  byte to serialize.
- in_dir  input  1  1 = left shift, 0 = right shift, matching the register's shift_dir encoding.
- sr_shift_dir  output  1  to register shift_dir.
- sr_data  output  8  to register data_in; the current serial bit replicated on all 8 bits, so both data_in[0] and data_in[7] carry it.
- frame_done  output  1  one-cycle pulse; the register now holds the completed byte.
- busy  output  1  high while in SHIFT, or while the FIFO is non-empty.
- fifo_count  output  log2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (reset=0, async) forces:
  - state IDLE, FIFO empty, fifo_count=0, in_ready=1;
  - sr_data = {8{IDLE_BIT}}, sr_shift_dir=0, frame_done=0, busy=0, bit counter=0.
  - Reset mid-frame abandons the frame and drops all FIFO contents.
- All outputs are registered, except in_ready, which is driven combinationally from FIFO state: in_ready = (count < FIFO_DEPTH).
- FIFO behaviour:
  - Write and pop may happen in the same cycle.
  - When full, a simultaneous pop does not make in_ready high in that same cycle; in_ready follows the registered count.
  - Count wraps nothing; pointers wrap modulo FIFO_DEPTH.
- State IDLE:
  - sr_data = all IDLE_BIT; sr_shift_dir holds its last value.
  - If the FIFO is non-empty at an edge: pop the head into the working byte and dir, and go to SHIFT with bit index k=0.
  - The first bit is presented in the cycle after the pop.
- State SHIFT, cycles k=0..7, each presents one bit:
  - dir=1 (left): present byte[7-k], MSB first.
  - dir=0 (right): present byte[k], LSB first.
  - sr_shift_dir = dir for all 8 cycles.
  - At the end of k=7:
    - If the FIFO is non-empty: pop the next entry and continue SHIFT with k=0, giving zero gap cycles between frames. A direction change takes effect on the new frame's first bit.
    - Otherwise: return to IDLE.
- frame_done:
  - High for exactly one cycle: the cycle after the k=7 bit was presented, i.e. after the register's 8th capturing edge.
  - With back-to-back frames it coincides with the next frame's k=0 cycle.
- Latency: first accepted byte into an empty, idle block:
  - handshake edge E0;
  - pop at E1;
  - bits on cycles E1..E8;
  - frame_done in cycle E9, when the register holds the byte.
- A write into an empty FIFO while IDLE is not bypassed; it takes the standard path above.
- in_valid without in_ready: no transfer; upstream holds its data.
- busy is 0 only in IDLE with an empty FIFO.

Test Plan:
- Reset then idle: reset low for 3 cycles, then release -> sr_data=8'h00, in_ready=1, busy=0, frame_done=0; register stays 8'h00 for 10 cycles.
- Single left frame: send in_data=8'hA5, in_dir=1 -> serial bits 1,0,1,0,0,1,0,1 on consecutive cycles with sr_shift_dir=1; frame_done pulses once; register reads 8'hA5 in that cycle.
- Single right frame: send 8'h3C, in_dir=0 -> bits 0,0,1,1,1,1,0,0 with sr_shift_dir=0; register reads 8'h3C at frame_done.
- Back-to-back, mixed direction: push 8'hF0 (left) then 8'h81 (right) on consecutive cycles -> 16 contiguous bit cycles with no gap; sr_shift_dir flips at bit 8; register reads 8'hF0 and then 8'h81 at the two frame_done pulses, which are exactly 8 cycles apart.
- FIFO full/backpressure: hold in_valid high with 6 distinct bytes while FIFO_DEPTH=4 -> in_ready drops when fifo_count=4; no byte is lost or duplicated; all 6 bytes emerge in order.
- Reset mid-frame: assert reset at bit k=3 of 8'hFF with 2 entries queued -> outputs return to reset values immediately; fifo_count=0; no frame_done; the next byte sent after release serializes correctly.

Source files
------------

// File: rtl/shift_frame_sequencer.sv
// shift_frame_sequencer
// Buffers {dir, byte} entries in a small FIFO and serializes each byte, one bit
// per clock, into a downstream 8-bit bidirectional shift register so that the
// register holds the byte after its 8th capturing edge. frame_done pulses in
// that cycle. Back-to-back frames run with no gap cycles.
module shift_frame_sequencer #(
    parameter int   FIFO_DEPTH = 4,
    parameter logic IDLE_BIT   = 1'b0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [7:0]                    in_data,
    input  logic                          in_dir,
    output logic                          sr_shift_dir,
    output logic [7:0]                    sr_data,
    output logic                          frame_done,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // Select the serial bit for position k: MSB first for left shifts,
    // LSB first for right shifts.
    function automatic logic pick_bit(input logic [7:0] b, input logic dir, input logic [2:0] k);
        logic bit_v;
        if (dir) begin
            bit_v = b[3'd7 - k];
        end else begin
            bit_v = b[k];
        end
        return bit_v;
    endfunction

    // FIFO storage and pointers
    logic [8:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Sequencer state
    state_t        state_q;
    logic [2:0]    k_q;
    logic [7:0]    byte_q;
    logic          dir_q;
    logic [7:0]    sr_data_q;
    logic          sr_shift_dir_q;
    logic          frame_done_q;
    logic          busy_q;

    logic          push_s;
    logic          pop_s;
    logic          shift_next_s;
    logic [7:0]    head_data_s;
    logic          head_dir_s;

    // Backpressure follows the registered occupancy only, so a pop while full
    // does not reopen the input in the same cycle.
    assign in_ready    = (count_q < CNT_FULL);
    assign push_s      = in_valid && in_ready;
    assign head_data_s = mem_q[rd_ptr_q][7:0];
    assign head_dir_s  = mem_q[rd_ptr_q][8];

    // Pop when idle with data waiting, or at the last bit of a frame so the
    // next frame starts without a gap.
    always_comb begin
        pop_s = 1'b0;
        if (count_q != CNT_ZERO) begin
            if (state_q == ST_IDLE) begin
                pop_s = 1'b1;
            end else if (k_q == 3'd7) begin
                pop_s = 1'b1;
            end else begin
                pop_s = 1'b0;
            end
        end else begin
            pop_s = 1'b0;
        end
    end

    // Whether the sequencer will be in SHIFT after the coming edge.
    always_comb begin
        shift_next_s = pop_s;
        if ((state_q == ST_SHIFT) && (k_q != 3'd7)) begin
            shift_next_s = 1'b1;
        end else begin
            shift_next_s = pop_s;
        end
    end

    // Next FIFO occupancy from simultaneous push/pop.
    always_comb begin
        count_d = count_q;
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // FIFO storage, pointers and occupancy; reset drops all contents.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= 9'h000;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= CNT_ZERO;
        end else begin
            if (push_s) begin
                mem_q[wr_ptr_q] <= {in_dir, in_data};
                wr_ptr_q        <= wr_ptr_q + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            count_q <= count_d;
        end
    end

    // Frame sequencer FSM with registered serial outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= ST_IDLE;
            k_q            <= 3'd0;
            byte_q         <= 8'h00;
            dir_q          <= 1'b0;
            sr_data_q      <= {8{IDLE_BIT}};
            sr_shift_dir_q <= 1'b0;
            frame_done_q   <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            frame_done_q <= (state_q == ST_SHIFT) && (k_q == 3'd7);
            busy_q       <= shift_next_s || (count_d != CNT_ZERO);
            case (state_q)
                ST_IDLE: begin
                    if (pop_s) begin
                        state_q        <= ST_SHIFT;
                        k_q            <= 3'd0;
                        byte_q         <= head_data_s;
                        dir_q          <= head_dir_s;
                        sr_data_q      <= {8{pick_bit(head_data_s, head_dir_s, 3'd0)}};
                        sr_shift_dir_q <= head_dir_s;
                    end else begin
                        sr_data_q <= {8{IDLE_BIT}};
                    end
                end
                ST_SHIFT: begin
                    if (k_q != 3'd7) begin
                        k_q       <= k_q + 3'd1;
                        sr_data_q <= {8{pick_bit(byte_q, dir_q, k_q + 3'd1)}};
                    end else if (pop_s) begin
                        k_q            <= 3'd0;
                        byte_q         <= head_data_s;
                        dir_q          <= head_dir_s;
                        sr_data_q      <= {8{pick_bit(head_data_s, head_dir_s, 3'd0)}};
                        sr_shift_dir_q <= head_dir_s;
                    end else begin
                        state_q   <= ST_IDLE;
                        k_q       <= 3'd0;
                        sr_data_q <= {8{IDLE_BIT}};
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    k_q       <= 3'd0;
                    sr_data_q <= {8{IDLE_BIT}};
                end
            endcase
        end
    end

    assign sr_data      = sr_data_q;
    assign sr_shift_dir = sr_shift_dir_q;
    assign frame_done   = frame_done_q;
    assign busy         = busy_q;
    assign fifo_count   = count_q;

endmodule
